// File: rtl/store_narrow_if.sv
// ---------------------------------------------------------------------------
// store_narrow_if : request and byte-memory signals of store_narrow
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface store_narrow_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_data;
  logic              req_word;
  logic              req_signed;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic              done;
  logic              trunc_err;

  modport master (
    output req_valid, req_addr, req_data, req_word, req_signed, mem_ack,
    input  req_ready, mem_wr_en, mem_addr, mem_wdata, done, trunc_err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_word, req_signed, mem_ack,
    output req_ready, mem_wr_en, mem_addr, mem_wdata, done, trunc_err
  );
endinterface

`default_nettype wire

// File: rtl/store_narrow.sv
// ---------------------------------------------------------------------------
// store_narrow : splits a 16-bit store into one or two byte writes
// Optional truncation check enabled by macro STORE_TRUNC_CHECK_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module store_narrow #(
  parameter int ADDR_W = 16
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  store_narrow_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR_LO = 2'd1,
    S_WR_HI = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_wr_en;
  logic              w_wr_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [7:0]        r_wdata;
  logic [7:0]        w_wdata;
  logic              r_done;
  logic              w_done;
  logic              w_accept;
  logic [7:0]        r_hi;
  logic              r_word;

`ifdef STORE_TRUNC_CHECK_EN
  logic              w_err;
  logic              r_err;
  logic              r_trunc;
  logic              w_trunc;

  // Byte store loses information when the upper byte is not the extension of the lower one
  always_comb begin
    w_err = 1'b0;
    if (!bus.req_word) begin
      if (bus.req_signed)
        w_err = (bus.req_data[15:8] != {8{bus.req_data[7]}});
      else
        w_err = (bus.req_data[15:8] != 8'h00);
    end
  end
`else
  logic              w_unused;
  assign w_unused = bus.req_signed;
`endif

  always_comb begin
    w_next_state = r_state;
    w_wr_en      = r_wr_en;
    w_mem_addr   = r_mem_addr;
    w_wdata      = r_wdata;
    w_done       = 1'b0;
    w_accept     = 1'b0;
`ifdef STORE_TRUNC_CHECK_EN
    w_trunc      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_WR_LO;
          w_wr_en      = 1'b1;
          w_mem_addr   = bus.req_addr;
          w_wdata      = bus.req_data[7:0];
        end
      end
      S_WR_LO: begin
        if (bus.mem_ack) begin
          if (r_word) begin
            w_next_state = S_WR_HI;
            w_mem_addr   = r_mem_addr + ADDR_W'(1);
            w_wdata      = r_hi;
          end else begin
            w_next_state = S_IDLE;
            w_wr_en      = 1'b0;
            w_done       = 1'b1;
`ifdef STORE_TRUNC_CHECK_EN
            w_trunc      = r_err;
`endif
          end
        end
      end
      S_WR_HI: begin
        if (bus.mem_ack) begin
          w_next_state = S_IDLE;
          w_wr_en      = 1'b0;
          w_done       = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_wr_en      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_wr_en    <= 1'b0;
      r_mem_addr <= '0;
      r_wdata    <= 8'h00;
      r_done     <= 1'b0;
      r_hi       <= 8'h00;
      r_word     <= 1'b0;
`ifdef STORE_TRUNC_CHECK_EN
      r_err      <= 1'b0;
      r_trunc    <= 1'b0;
`endif
    end else begin
      r_state    <= w_next_state;
      r_wr_en    <= w_wr_en;
      r_mem_addr <= w_mem_addr;
      r_wdata    <= w_wdata;
      r_done     <= w_done;
`ifdef STORE_TRUNC_CHECK_EN
      r_trunc    <= w_trunc;
`endif
      if (w_accept) begin
        r_hi   <= bus.req_data[15:8];
        r_word <= bus.req_word;
`ifdef STORE_TRUNC_CHECK_EN
        r_err  <= w_err;
`endif
      end
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.mem_wr_en = r_wr_en;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.done      = r_done;
`ifdef STORE_TRUNC_CHECK_EN
  assign bus.trunc_err = r_trunc;
`else
  assign bus.trunc_err = 1'b0;
`endif

endmodule

`default_nettype wire
